// File: rtl/aes_output_chain_pkg.sv
// Shared definitions for the AES mode output stage: block width, mode codes
// (also consumed by the input mux) and output-register FSM encodings.
package aes_output_chain_pkg;

  localparam int BLOCK_W = 128;

  typedef logic [BLOCK_W-1:0] block_t;

  localparam logic [2:0] MODE_ECB = 3'd0;
  localparam logic [2:0] MODE_CBC = 3'd1;
  localparam logic [2:0] MODE_CFB = 3'd2;
  localparam logic [2:0] MODE_OFB = 3'd3;
  localparam logic [2:0] MODE_CTR = 3'd4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Stream modes combine the core output with the plaintext; codes 5-7 behave as ECB.
  function automatic logic mode_xors_pt(input logic [2:0] m);
    return (m == MODE_CFB) || (m == MODE_OFB) || (m == MODE_CTR);
  endfunction

endpackage

// File: rtl/aes_output_chain_if.sv
// Core-result and ciphertext handshakes of the AES output stage.
// slave = the output stage itself, master = the surrounding core/sink.
interface aes_output_chain_if;
  import aes_output_chain_pkg::*;

  logic   core_valid;
  logic   core_ready;
  block_t core_out;
  block_t pt_in;
  logic   ct_valid;
  logic   ct_ready;
  block_t ct_out;

  modport slave (
    input  core_valid, core_out, pt_in, ct_ready,
    output core_ready, ct_valid, ct_out
  );

  modport master (
    output core_valid, core_out, pt_in, ct_ready,
    input  core_ready, ct_valid, ct_out
  );

endinterface

// File: rtl/aes_ctr_inc.sv
// Counter-field incrementer (modulo 2^W) with an all-ones flag that marks the
// value about to wrap.
module aes_ctr_inc #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  output logic [W-1:0] inc_o,
  output logic         all_ones_o
);

  assign inc_o      = val_i + W'(1);
  assign all_ones_o = &val_i;

endmodule

// File: rtl/aes_output_chain.sv
// AES mode output stage: forms ciphertext, keeps feedback/counter chaining state.
// Optional sticky counter-wrap flag enabled by AES_OUT_CTR_WRAP_ERR_EN.
module aes_output_chain
  import aes_output_chain_pkg::*;
#(
  parameter int CTR_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          mode,
  input  logic                iv_load,
  input  block_t              iv,
  input  block_t              ctr_init,
  aes_output_chain_if.slave   bus,
  output block_t              feedback,
  output block_t              ctr,
  output logic                ctr_wrap_err
);

  state_e state_q, state_d;
  block_t ct_out_q, ct_out_d;
  block_t feedback_q, feedback_d;
  block_t ctr_q, ctr_d;
  block_t ct_calc;
  block_t ctr_stepped;

  logic [CTR_WIDTH-1:0] ctr_lo_inc;
  logic                 ctr_lo_ones;
  logic                 accept;

  aes_ctr_inc #(.W(CTR_WIDTH)) u_ctr_inc (
    .val_i      (ctr_q[CTR_WIDTH-1:0]),
    .inc_o      (ctr_lo_inc),
    .all_ones_o (ctr_lo_ones)
  );

  generate
    if (CTR_WIDTH < BLOCK_W) begin : g_ctr_split
      assign ctr_stepped = {ctr_q[BLOCK_W-1:CTR_WIDTH], ctr_lo_inc};
    end else begin : g_ctr_full
      assign ctr_stepped = ctr_lo_inc;
    end
  endgenerate

  // Ready while empty or while the held block leaves this cycle: no bubble.
  assign bus.core_ready = (state_q == ST_EMPTY) | bus.ct_ready;
  assign accept         = bus.core_valid & bus.core_ready;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    ct_calc    = bus.core_out;
    state_d    = state_q;
    ct_out_d   = ct_out_q;
    feedback_d = feedback_q;
    ctr_d      = ctr_q;

    if (mode_xors_pt(mode)) begin
      ct_calc = bus.core_out ^ bus.pt_in;
    end

    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (!accept && bus.ct_ready) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase

    if (accept) begin
      ct_out_d = ct_calc;
      case (mode)
        MODE_CBC: feedback_d = bus.core_out;
        MODE_CFB: feedback_d = ct_calc;
        MODE_OFB: feedback_d = bus.core_out;
        MODE_CTR: ctr_d      = ctr_stepped;
        default:  ;
      endcase
    end

    // A reload overrides the chaining update of a block accepted the same cycle.
    if (iv_load) begin
      feedback_d = iv;
      ctr_d      = ctr_init;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      ct_out_q   <= '0;
      feedback_q <= '0;
      ctr_q      <= '0;
    end else begin
      state_q    <= state_d;
      ct_out_q   <= ct_out_d;
      feedback_q <= feedback_d;
      ctr_q      <= ctr_d;
    end
  end

`ifdef AES_OUT_CTR_WRAP_ERR_EN
  logic wrap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q <= 1'b0;
    end else if (iv_load) begin
      wrap_q <= 1'b0;
    end else if (accept && (mode == MODE_CTR) && ctr_lo_ones) begin
      wrap_q <= 1'b1;
    end
  end

  assign ctr_wrap_err = wrap_q;
`else
  logic ctr_wrap_unused;

  assign ctr_wrap_unused = ctr_lo_ones;
  assign ctr_wrap_err    = 1'b0;
`endif

  assign bus.ct_valid = (state_q == ST_FULL);
  assign bus.ct_out   = ct_out_q;
  assign feedback     = feedback_q;
  assign ctr          = ctr_q;

endmodule

// File: tb/tb_aes_output_chain.sv
// Scoreboard bench for aes_output_chain: directed blocks push expected
// ciphertext; a monitor pops and compares on every ct handshake.
module tb_aes_output_chain;
  import aes_output_chain_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic [2:0] mode = MODE_ECB;
  logic   iv_load = 1'b0;
  block_t iv = '0;
  block_t ctr_init = '0;
  block_t feedback;
  block_t ctr;
  logic   ctr_wrap_err;

  int n_cmp = 0;
  int n_mis = 0;
  block_t exp_q[$];

`ifdef AES_OUT_CTR_WRAP_ERR_EN
  localparam logic WRAP_EXP = 1'b1;
`else
  localparam logic WRAP_EXP = 1'b0;
`endif

  localparam block_t IV1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam block_t CTR1  = 128'h00112233445566778899aabb00000005;
  localparam block_t CTRW  = 128'hdeadbeef0123456789abcdefffffffff;
  localparam block_t IV2   = 128'h0badc0de0badc0de0badc0de0badc0de;
  localparam block_t CTR2  = 128'h99999999888888887777777766666666;

  aes_output_chain_if bus ();

  aes_output_chain #(.CTR_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode         (mode),
    .iv_load      (iv_load),
    .iv           (iv),
    .ctr_init     (ctr_init),
    .bus          (bus.slave),
    .feedback     (feedback),
    .ctr          (ctr),
    .ctr_wrap_err (ctr_wrap_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input block_t act, input block_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every completed ciphertext transfer is compared in order.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.ct_valid && bus.ct_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_ct: got %h expected no output", bus.ct_out);
        end else begin
          check("ct_out", bus.ct_out, exp_q.pop_front());
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge with core_valid still high.
  task automatic send(input logic [2:0] m, input block_t co, input block_t pt,
                      input block_t exp, output int waits);
    logic got;
    mode            = m;
    bus.core_out    = co;
    bus.pt_in       = pt;
    bus.core_valid  = 1'b1;
    exp_q.push_back(exp);
    got   = 1'b0;
    waits = 0;
    while (!got && waits < 20) begin
      @(negedge clk);
      if (bus.core_ready) got = 1'b1;
      else waits++;
    end
    check("accept_in_time", block_t'(got), block_t'(1));
    if (got) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    bus.core_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input block_t v, input block_t c);
    iv       = v;
    ctr_init = c;
    iv_load  = 1'b1;
    @(posedge clk);
    #1;
    iv_load  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bus.core_valid = 1'b0;
    bus.core_out   = '0;
    bus.pt_in      = '0;
    bus.ct_ready   = 1'b0;

    #2;
    check("rst_ct_valid", block_t'(bus.ct_valid), '0);
    check("rst_ct_out", bus.ct_out, '0);
    check("rst_feedback", feedback, '0);
    check("rst_ctr", ctr, '0);
    check("rst_wrap", block_t'(ctr_wrap_err), '0);
    check("rst_core_ready", block_t'(bus.core_ready), block_t'(1));
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    load(IV1, CTR1);
    check("load_feedback", feedback, IV1);
    check("load_ctr", ctr, CTR1);
    check("load_no_valid", block_t'(bus.ct_valid), '0);

    // ECB
    bus.ct_ready = 1'b1;
    send(MODE_ECB, 128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'h6bc1bee22e409f96e93d7e117393172a,
         128'h3ad77bb40d7a3660a89ecaf32466ef97, w);
    check("ecb_valid", block_t'(bus.ct_valid), block_t'(1));
    check("ecb_ct_direct", bus.ct_out, 128'h3ad77bb40d7a3660a89ecaf32466ef97);
    check("ecb_feedback", feedback, IV1);
    check("ecb_ctr", ctr, CTR1);
    idle(2);

    // CBC back-to-back
    send(MODE_CBC, 128'h11111111222222223333333344444444, '1,
         128'h11111111222222223333333344444444, w);
    check("cbc1_feedback", feedback, 128'h11111111222222223333333344444444);
    check("cbc1_core_ready", block_t'(bus.core_ready), block_t'(1));
    send(MODE_CBC, 128'hcafebabedeadbeef0102030405060708, '1,
         128'hcafebabedeadbeef0102030405060708, w);
    check("cbc2_no_bubble", block_t'(w), '0);
    check("cbc2_feedback", feedback, 128'hcafebabedeadbeef0102030405060708);
    idle(2);

    // CTR with counter wrap
    load(IV1, CTRW);
    send(MODE_CTR, 128'h00112233445566778899aabbccddeeff, 128'hffffffffffffffff0000000000000000,
         128'hffeeddccbbaa99888899aabbccddeeff, w);
    check("ctr_wrap_value", ctr, 128'hdeadbeef0123456789abcdef00000000);
    check("ctr_wrap_flag", block_t'(ctr_wrap_err), block_t'(WRAP_EXP));
    send(MODE_CTR, {4{32'h12345678}}, {4{32'h0000ffff}}, {4{32'h1234a987}}, w);
    check("ctr_step_value", ctr, 128'hdeadbeef0123456789abcdef00000001);
    check("ctr_wrap_sticky", block_t'(ctr_wrap_err), block_t'(WRAP_EXP));
    check("ctr_feedback", feedback, IV1);

    // OFB, CFB, reserved mode
    send(MODE_OFB, {16{8'h0f}}, '1, {16{8'hf0}}, w);
    check("ofb_feedback", feedback, {16{8'h0f}});
    check("ofb_ctr", ctr, 128'hdeadbeef0123456789abcdef00000001);
    send(MODE_CFB, 128'haaaaaaaaaaaaaaaa5555555555555555, 128'hffffffff00000000ffffffff00000000,
         128'h55555555aaaaaaaaaaaaaaaa55555555, w);
    check("cfb_feedback", feedback, 128'h55555555aaaaaaaaaaaaaaaa55555555);
    send(3'd5, {8{16'h5a5a}}, '1, {8{16'h5a5a}}, w);
    check("mode5_feedback", feedback, 128'h55555555aaaaaaaaaaaaaaaa55555555);
    idle(2);

    // Reload coincident with an accept: ciphertext from old state, reload wins
    iv       = IV2;
    ctr_init = CTR2;
    iv_load  = 1'b1;
    send(MODE_CBC, 128'h0123456789abcdeffedcba9876543210, '0,
         128'h0123456789abcdeffedcba9876543210, w);
    iv_load  = 1'b0;
    check("ivacc_feedback", feedback, IV2);
    check("ivacc_ctr", ctr, CTR2);
    check("ivacc_wrap_clr", block_t'(ctr_wrap_err), '0);
    idle(2);

    // Back-pressure
    bus.ct_ready = 1'b0;
    send(MODE_ECB, 128'hb1b1b1b1b1b1b1b1b1b1b1b1b1b1b1b1, '0,
         128'hb1b1b1b1b1b1b1b1b1b1b1b1b1b1b1b1, w);
    bus.core_out = 128'hb2b2b2b2b2b2b2b2b2b2b2b2b2b2b2b2;
    exp_q.push_back(128'hb2b2b2b2b2b2b2b2b2b2b2b2b2b2b2b2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_core_ready", block_t'(bus.core_ready), '0);
      check("bp_ct_valid", block_t'(bus.ct_valid), block_t'(1));
      check("bp_ct_stable", bus.ct_out, 128'hb1b1b1b1b1b1b1b1b1b1b1b1b1b1b1b1);
    end
    @(posedge clk);
    #1;
    bus.ct_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.core_valid = 1'b0;
    check("bp_release", bus.ct_out, 128'hb2b2b2b2b2b2b2b2b2b2b2b2b2b2b2b2);
    idle(2);

    // Asynchronous reset while holding a block
    bus.ct_ready   = 1'b0;
    mode           = MODE_ECB;
    bus.core_out   = 128'hc3c3c3c3c3c3c3c3c3c3c3c3c3c3c3c3;
    bus.core_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.core_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_full", block_t'(bus.ct_valid), block_t'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ct_valid", block_t'(bus.ct_valid), '0);
    check("async_rst_feedback", feedback, '0);
    check("async_rst_ctr", ctr, '0);
    check("async_rst_ct_out", bus.ct_out, '0);
    #4 rst_n = 1'b1;
    idle(3);

    check("scoreboard_drained", block_t'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
